// File: rtl/dmem_responder.sv
// Memory-side end of the DMEM request/acknowledge interface: accepts one access at a time,
// holds it for LATENCY cycles, commits it to an internal word array and pulses an acknowledge.
module dmem_responder #(
    parameter int MEM_ADDR_WIDTH = 32,
    parameter int MEM_DATA_WIDTH = 32,
    parameter int DEPTH_WORDS    = 1024,
    parameter int LATENCY        = 2
) (
    input  logic                      clk_i,
    input  logic                      arst_ni,
    input  logic                      dmem_req_i,
    input  logic [MEM_ADDR_WIDTH-1:0] dmem_addr_i,
    input  logic                      dmem_we_i,
    input  logic [MEM_DATA_WIDTH-1:0] dmem_wdata_i,
    output logic [MEM_DATA_WIDTH-1:0] dmem_rdata_o,
    output logic                      dmem_ack_o,
    output logic                      dmem_err_o,
    output logic                      busy_o
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [MEM_ADDR_WIDTH:0] ADDR_LIMIT = (MEM_ADDR_WIDTH + 1)'(4 * DEPTH_WORDS);

    if (MEM_DATA_WIDTH != 32) begin : g_bad_width
        $error("dmem_responder: MEM_DATA_WIDTH must be 32");
    end
    if (LATENCY < 1 || LATENCY > 16) begin : g_bad_latency
        $error("dmem_responder: LATENCY must be in 1..16");
    end
    if ((1 << IDX_W) != DEPTH_WORDS) begin : g_bad_depth
        $error("dmem_responder: DEPTH_WORDS must be a power of two");
    end

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t                    state;
    logic [CNT_W-1:0]          cnt_p0;
    logic [MEM_ADDR_WIDTH-1:0] addr_p0;
    logic                      we_p0;
    logic [MEM_DATA_WIDTH-1:0] wdata_p0;

    logic [MEM_DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    logic                      accept;
    logic                      commit;
    logic [MEM_ADDR_WIDTH-1:0] c_addr;
    logic                      c_we;
    logic [MEM_DATA_WIDTH-1:0] c_wdata;
    logic                      c_legal;
    logic [IDX_W-1:0]          c_idx;
    logic [MEM_DATA_WIDTH-1:0] c_rdata;

    function automatic logic is_legal(input logic [MEM_ADDR_WIDTH-1:0] a);
        return (a[1:0] == 2'b00) && ({1'b0, a} < ADDR_LIMIT);
    endfunction

    // With LATENCY = 1 the commit shares the accept edge, so it must use the live inputs;
    // otherwise the commit happens from WAIT and only the captured copy is trusted.
    always_comb begin
        accept  = (state == IDLE) && dmem_req_i;
        commit  = ((state == WAIT) && (cnt_p0 == CNT_W'(1))) || (accept && (LATENCY == 1));
        c_addr  = (state == IDLE) ? dmem_addr_i  : addr_p0;
        c_we    = (state == IDLE) ? dmem_we_i    : we_p0;
        c_wdata = (state == IDLE) ? dmem_wdata_i : wdata_p0;
        c_legal = is_legal(c_addr);
        c_idx   = c_addr[IDX_W+1:2];
        c_rdata = (c_legal && !c_we) ? mem[c_idx] : '0;
    end

    // Array has no reset; the arst_ni term keeps a held request from writing while in reset.
    always_ff @(posedge clk_i) begin
        if (arst_ni && commit && c_we && c_legal) begin
            mem[c_idx] <= c_wdata;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state        <= IDLE;
            cnt_p0       <= '0;
            addr_p0      <= '0;
            we_p0        <= 1'b0;
            wdata_p0     <= '0;
            dmem_ack_o   <= 1'b0;
            dmem_err_o   <= 1'b0;
            dmem_rdata_o <= '0;
            busy_o       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_p0  <= dmem_addr_i;
                        we_p0    <= dmem_we_i;
                        wdata_p0 <= dmem_wdata_i;
                        cnt_p0   <= CNT_LOAD;
                        busy_o   <= 1'b1;
                        if (commit) begin
                            state        <= RESP;
                            dmem_ack_o   <= 1'b1;
                            dmem_err_o   <= ~c_legal;
                            dmem_rdata_o <= c_rdata;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt_p0 <= cnt_p0 - CNT_W'(1);
                    if (commit) begin
                        state        <= RESP;
                        dmem_ack_o   <= 1'b1;
                        dmem_err_o   <= ~c_legal;
                        dmem_rdata_o <= c_rdata;
                    end
                end
                RESP: begin
                    state        <= IDLE;
                    dmem_ack_o   <= 1'b0;
                    dmem_err_o   <= 1'b0;
                    dmem_rdata_o <= '0;
                    busy_o       <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 1, 16) checked every cycle against a
// transaction-level timing/memory model, plus directed scenarios with literal expectations.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        arst_n;
    logic        req   [3];
    logic [31:0] addr  [3];
    logic        we    [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic        ack   [3];
    logic        err   [3];
    logic        busy  [3];

    int total = 0;
    int bad   = 0;
    int ncyc  = 0;

    dmem_responder #(.MEM_ADDR_WIDTH(32), .MEM_DATA_WIDTH(32), .DEPTH_WORDS(1024), .LATENCY(2)) u_lat2 (
        .clk_i(clk), .arst_ni(arst_n), .dmem_req_i(req[0]), .dmem_addr_i(addr[0]), .dmem_we_i(we[0]),
        .dmem_wdata_i(wdata[0]), .dmem_rdata_o(rdata[0]), .dmem_ack_o(ack[0]), .dmem_err_o(err[0]),
        .busy_o(busy[0]));
    dmem_responder #(.MEM_ADDR_WIDTH(32), .MEM_DATA_WIDTH(32), .DEPTH_WORDS(1024), .LATENCY(1)) u_lat1 (
        .clk_i(clk), .arst_ni(arst_n), .dmem_req_i(req[1]), .dmem_addr_i(addr[1]), .dmem_we_i(we[1]),
        .dmem_wdata_i(wdata[1]), .dmem_rdata_o(rdata[1]), .dmem_ack_o(ack[1]), .dmem_err_o(err[1]),
        .busy_o(busy[1]));
    dmem_responder #(.MEM_ADDR_WIDTH(32), .MEM_DATA_WIDTH(32), .DEPTH_WORDS(1024), .LATENCY(16)) u_lat16 (
        .clk_i(clk), .arst_ni(arst_n), .dmem_req_i(req[2]), .dmem_addr_i(addr[2]), .dmem_we_i(we[2]),
        .dmem_wdata_i(wdata[2]), .dmem_rdata_o(rdata[2]), .dmem_ack_o(ack[2]), .dmem_err_o(err[2]),
        .busy_o(busy[2]));

    function automatic int lat_of(input int k);
        case (k)
            0:       return 2;
            1:       return 1;
            default: return 16;
        endcase
    endfunction

    // Model: a transaction accepted at edge E occupies cycles 1..L after it; the array
    // access happens at edge E+L-1 and the next accept can happen at edge E+L+1 or later.
    logic [31:0] mm [3][1024];
    bit          mv [3][1024];
    bit          act   [3];
    int          acc_e [3];
    logic [31:0] ca [3];
    logic        cw [3];
    logic [31:0] cd [3];
    logic        e_ack [3];
    logic        e_busy [3];
    logic        e_err [3];
    logic [31:0] e_rd [3];
    bit          e_known [3];

    task automatic model_clear();
        for (int k = 0; k < 3; k++) begin
            act[k] = 0; e_ack[k] = 0; e_busy[k] = 0; e_err[k] = 0; e_rd[k] = 0; e_known[k] = 1;
        end
    endtask

    task automatic model_step();
        int d;
        bit legal;
        ncyc++;
        for (int k = 0; k < 3; k++) begin
            e_ack[k] = 0; e_busy[k] = 0; e_err[k] = 0; e_rd[k] = 0; e_known[k] = 1;
            if (arst_n !== 1'b1) begin
                act[k] = 0;
            end else begin
                if (act[k] && ncyc > acc_e[k] + lat_of(k)) act[k] = 0;
                if (!act[k] && req[k] === 1'b1) begin
                    act[k] = 1; acc_e[k] = ncyc; ca[k] = addr[k]; cw[k] = we[k]; cd[k] = wdata[k];
                end
                if (act[k]) begin
                    d = ncyc - acc_e[k];
                    if (d < lat_of(k)) e_busy[k] = 1;
                    if (d == lat_of(k) - 1) begin
                        e_ack[k] = 1;
                        legal = (ca[k] % 4 == 0) && (ca[k] < 32'h1000);
                        if (!legal) e_err[k] = 1;
                        else if (cw[k]) begin
                            mm[k][ca[k] / 4] = cd[k];
                            mv[k][ca[k] / 4] = 1;
                        end else begin
                            e_rd[k]    = mm[k][ca[k] / 4];
                            e_known[k] = mv[k][ca[k] / 4];
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial forever begin
        @(negedge arst_n);
        model_clear();
    end

    task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s inst%0d got=%h want=%h t=%0t", nm, k, got, want, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("cyc_ack", k, 32'(ack[k]), 32'(e_ack[k]));
            chk("cyc_busy", k, 32'(busy[k]), 32'(e_busy[k]));
            chk("cyc_err", k, 32'(err[k]), 32'(e_err[k]));
            if (e_known[k]) chk("cyc_rdata", k, rdata[k], e_rd[k]);
        end
    end

    // Called at a negedge; returns in the ack cycle with req still high so calls can chain.
    task automatic txn(input int k, input logic [31:0] a, input logic w, input logic [31:0] dat,
                       input bit scramble, output logic [31:0] rd, output logic er, output int at);
        bit got = 0;
        req[k] = 1'b1; addr[k] = a; we[k] = w; wdata[k] = dat;
        rd = '0; er = 1'b0; at = -1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (ack[k] === 1'b1) begin
                got = 1; rd = rdata[k]; er = err[k]; at = ncyc;
                break;
            end
            if (scramble) begin
                addr[k] = $urandom; wdata[k] = $urandom; we[k] = 1'($urandom);
            end
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL ack_timeout inst%0d got=no_ack want=ack", k);
        end
    endtask

    task automatic rand_run(input int k, input int n);
        logic [31:0] a, rd;
        logic er;
        int at, r;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(3) == 0) begin
                req[k] = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            r = $urandom_range(9);
            if (r <= 6)      a = 32'($urandom_range(15)) << 2;
            else if (r == 7) a = (32'($urandom_range(15)) << 2) | 32'($urandom_range(1, 3));
            else if (r == 8) a = 32'h1000 + (32'($urandom_range(255)) << 2);
            else             a = 32'hFFFF_FFFC;
            txn(k, a, 1'($urandom), $urandom, 1'($urandom), rd, er, at);
        end
        req[k] = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          at, t0;

    initial begin
        arst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req[k] = 1'b0; addr[k] = '0; we[k] = 1'b0; wdata[k] = '0;
        end
        repeat (3) @(negedge clk);
        arst_n = 1'b1;

        // reset asserted mid-clock while every instance holds a transaction
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin req[k] = 1'b1; addr[k] = 32'h4; we[k] = 1'b0; end
        @(negedge clk);
        #2 arst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_ack", k, 32'(ack[k]), 32'h0);
            chk("rst_busy", k, 32'(busy[k]), 32'h0);
            chk("rst_err", k, 32'(err[k]), 32'h0);
            chk("rst_rdata", k, rdata[k], 32'h0);
        end
        for (int k = 0; k < 3; k++) req[k] = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) chk("post_rst_ack", k, 32'(ack[k]), 32'h0);
        end

        // LATENCY 2: store then load, back-to-back with req held
        @(negedge clk); t0 = ncyc;
        txn(0, 32'h10, 1'b1, 32'hDEADBEEF, 0, rd, er, at);
        chk("st_ack_cycle", 0, 32'(at - t0), 32'd2);
        chk("st_err", 0, 32'(er), 32'h0);
        txn(0, 32'h10, 1'b0, 32'h0, 0, rd, er, at);
        chk("ld_ack_cycle", 0, 32'(at - t0), 32'd5);
        chk("ld_rdata", 0, rd, 32'hDEADBEEF);
        for (int i = 0; i < 3; i++) txn(0, 32'(i * 4), 1'b1, 32'(i + 1), 0, rd, er, at);
        req[0] = 1'b0;
        @(negedge clk); t0 = ncyc;
        for (int i = 0; i < 3; i++) begin
            txn(0, 32'(i * 4), 1'b0, 32'h0, 0, rd, er, at);
            chk("b2b_cycle", 0, 32'(at - t0), 32'(2 + 3 * i));
            chk("b2b_rdata", 0, rd, 32'(i + 1));
        end

        // illegal accesses
        txn(0, 32'h13, 1'b1, 32'h5555, 0, rd, er, at);
        chk("misalign_err", 0, 32'(er), 32'h1);
        txn(0, 32'h10, 1'b0, 32'h0, 0, rd, er, at);
        chk("after_bad_st", 0, rd, 32'hDEADBEEF);
        txn(0, 32'h1000, 1'b0, 32'h0, 0, rd, er, at);
        chk("oor_err", 0, 32'(er), 32'h1);
        chk("oor_rdata", 0, rd, 32'h0);
        req[0] = 1'b0;

        // LATENCY 1
        @(negedge clk); t0 = ncyc;
        txn(1, 32'h40, 1'b1, 32'h77, 0, rd, er, at);
        chk("l1_ack_cycle", 1, 32'(at - t0), 32'd1);
        txn(1, 32'h40, 1'b0, 32'h0, 0, rd, er, at);
        chk("l1_ld_cycle", 1, 32'(at - t0), 32'd3);
        chk("l1_rdata", 1, rd, 32'h77);
        req[1] = 1'b0;

        // LATENCY 16 with inputs scrambled during WAIT
        @(negedge clk); t0 = ncyc;
        txn(2, 32'h40, 1'b1, 32'hCAFEF00D, 1, rd, er, at);
        chk("l16_ack_cycle", 2, 32'(at - t0), 32'd16);
        chk("l16_err", 2, 32'(er), 32'h0);
        txn(2, 32'h40, 1'b0, 32'h0, 0, rd, er, at);
        chk("l16_rdata", 2, rd, 32'hCAFEF00D);
        req[2] = 1'b0;

        // reset during WAIT discards the pending store
        @(negedge clk);
        txn(0, 32'h20, 1'b1, 32'h1, 0, rd, er, at);
        req[0] = 1'b0;
        @(negedge clk);
        req[0] = 1'b1; addr[0] = 32'h20; we[0] = 1'b1; wdata[0] = 32'hA5A5A5A5;
        @(negedge clk);
        chk("wait_busy", 0, 32'(busy[0]), 32'h1);
        #2 arst_n = 1'b0;
        #1 chk("wait_rst_ack", 0, 32'(ack[0]), 32'h0);
        req[0] = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("wait_rst_noack", 0, 32'(ack[0]), 32'h0);
        end
        txn(0, 32'h20, 1'b0, 32'h0, 0, rd, er, at);
        chk("wait_rst_keep", 0, rd, 32'h1);
        req[0] = 1'b0;

        @(negedge clk);
        fork
            rand_run(0, 150);
            rand_run(1, 150);
            rand_run(2, 40);
        join
        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
